// File: rtl/tdm_frame_scheduler.sv
// tdm_frame_scheduler
// Transmit-side TDM framer. Gathers one word per channel over valid/ready,
// serialises the words MSB first into fixed slots (slot 0 first), marks the
// first bit of every frame with tdm_sync and substitutes IDLE_WORD for any
// slot whose source had nothing to offer, flagging that slot as underrun.
module tdm_frame_scheduler #(
  parameter int                NUM_CH    = 5,
  parameter int                WORD_W    = 32,
  parameter int                FRAME_GAP = 0,
  parameter logic [WORD_W-1:0] IDLE_WORD = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH*WORD_W-1:0]   ch_data,
  output logic [NUM_CH-1:0]          ch_ready,
  input  logic                       clr_status,
  output logic                       tdm_data,
  output logic                       tdm_sync,
  output logic                       busy,
  output logic [$clog2(NUM_CH)-1:0]  slot,
  output logic [NUM_CH-1:0]          underrun,
  output logic [15:0]                frame_count
);

  localparam int SLOT_W = $clog2(NUM_CH);
  localparam int BIT_W  = $clog2(WORD_W);
  localparam int GAP_W  = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WORD_W - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CH - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);
  localparam bit                HAS_GAP   = (FRAME_GAP > 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t              r_state;
  state_t              w_nextState;

  logic [WORD_W-1:0]   r_shreg;
  logic [BIT_W-1:0]    r_bitCnt;
  logic [SLOT_W-1:0]   r_slot;
  logic [GAP_W-1:0]    r_gapCnt;
  logic [15:0]         r_frameCount;
  logic [NUM_CH-1:0]   r_underrun;

  logic                w_inShift;
  logic                w_wordEnd;
  logic                w_lastSlot;
  logic                w_gapEnd;
  logic                w_frameEnd;
  logic                w_loadActive;
  logic [SLOT_W-1:0]   w_loadSlot;
  logic [WORD_W-1:0]   w_loadWord;
  logic [NUM_CH-1:0]   w_readyVec;
  logic [NUM_CH-1:0]   w_underSet;

  assign w_inShift  = (r_state == S_SHIFT);
  assign w_wordEnd  = (r_bitCnt == BIT_LAST);
  assign w_lastSlot = (r_slot == SLOT_LAST);
  assign w_gapEnd   = (r_gapCnt == GAP_LAST);
  assign w_frameEnd = w_inShift && w_wordEnd && w_lastSlot;

  // State register; an async reset abandons any frame in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; enable is only consulted at frame boundaries.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_nextState = S_PREP;
        end
      end
      S_PREP: begin
        w_nextState = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_frameEnd) begin
          if (HAS_GAP) begin
            w_nextState = S_GAP;
          end else if (!enable) begin
            w_nextState = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (w_gapEnd) begin
          w_nextState = enable ? S_SHIFT : S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Output decode: decide whether this cycle loads a slot and which one.
  always_comb begin
    w_loadActive = 1'b0;
    w_loadSlot   = '0;
    case (r_state)
      S_PREP: begin
        w_loadActive = 1'b1;
      end
      S_SHIFT: begin
        if (w_wordEnd) begin
          if (!w_lastSlot) begin
            w_loadActive = 1'b1;
            w_loadSlot   = r_slot + SLOT_W'(1);
          end else if (!HAS_GAP && enable) begin
            w_loadActive = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (w_gapEnd && enable) begin
          w_loadActive = 1'b1;
        end
      end
      default: begin
        w_loadActive = 1'b0;
      end
    endcase
  end

  // Load mux: pick the selected source word, or IDLE_WORD and an underrun flag.
  always_comb begin
    w_loadWord = IDLE_WORD;
    w_readyVec = '0;
    w_underSet = '0;
    for (int s = 0; s < NUM_CH; s++) begin
      if (w_loadActive && (w_loadSlot == SLOT_W'(s))) begin
        if (ch_valid[s]) begin
          w_readyVec[s] = 1'b1;
          w_loadWord    = ch_data[s*WORD_W +: WORD_W];
        end else begin
          w_underSet[s] = 1'b1;
        end
      end
    end
  end

  // Datapath: shift register, bit/slot/gap counters, frame counter, status.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shreg      <= '0;
      r_bitCnt     <= '0;
      r_slot       <= '0;
      r_gapCnt     <= '0;
      r_frameCount <= '0;
      r_underrun   <= '0;
    end else begin
      if (w_loadActive) begin
        r_shreg <= w_loadWord;
      end else if (w_inShift && !w_wordEnd) begin
        r_shreg <= {r_shreg[WORD_W-2:0], 1'b0};
      end else begin
        r_shreg <= '0;
      end

      if (w_inShift && !w_wordEnd) begin
        r_bitCnt <= r_bitCnt + BIT_W'(1);
      end else begin
        r_bitCnt <= '0;
      end

      if (w_inShift && w_wordEnd) begin
        r_slot <= w_lastSlot ? '0 : r_slot + SLOT_W'(1);
      end else if (!w_inShift) begin
        r_slot <= '0;
      end

      if (r_state == S_GAP) begin
        r_gapCnt <= r_gapCnt + GAP_W'(1);
      end else begin
        r_gapCnt <= '0;
      end

      if (w_frameEnd) begin
        r_frameCount <= r_frameCount + 16'd1;
      end

      r_underrun <= clr_status ? w_underSet : (r_underrun | w_underSet);
    end
  end

  assign ch_ready    = w_readyVec;
  assign tdm_data    = r_shreg[WORD_W-1];
  assign tdm_sync    = w_inShift && (r_slot == '0) && (r_bitCnt == '0);
  assign busy        = (r_state != S_IDLE);
  assign slot        = r_slot;
  assign underrun    = r_underrun;
  assign frame_count = r_frameCount;

endmodule

// File: tb/tb_tdm_frame_scheduler.sv
// tb_tdm_frame_scheduler
// Drives two schedulers (back-to-back frames and a 4-cycle inter-frame gap
// with a non-zero idle word) from the same sources and compares every cycle
// against a position-in-frame model, plus a few hand-computed expectations.
module tb_tdm_frame_scheduler;

  localparam int NCH = 5;
  localparam int W   = 32;
  localparam int FB  = NCH * W;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic                 enable = 1'b0;
  logic                 clr_status = 1'b0;
  logic [NCH-1:0]       ch_valid = '0;
  logic [NCH*W-1:0]     ch_data = '0;

  logic [NCH-1:0]       dReady [2];
  logic                 dTdm   [2];
  logic                 dSync  [2];
  logic                 dBusy  [2];
  logic [2:0]           dSlot  [2];
  logic [NCH-1:0]       dUnder [2];
  logic [15:0]          dCount [2];

  int checks = 0;
  int errors = 0;

  int syncCnt = 0;
  int readyCnt [NCH];

  bit               mBusy  [2];
  int               mPos   [2];
  logic [W-1:0]     mWords [2][NCH];
  bit [NCH-1:0]     mUnder [2];
  bit [15:0]        mCount [2];

  // Free-running clock, 10 time units per TDM bit.
  always #5 clock = ~clock;

  tdm_frame_scheduler #(
    .NUM_CH(NCH), .WORD_W(W), .FRAME_GAP(0), .IDLE_WORD(32'h00000000)
  ) u0 (
    .clock(clock), .reset(reset), .enable(enable), .ch_valid(ch_valid),
    .ch_data(ch_data), .ch_ready(dReady[0]), .clr_status(clr_status),
    .tdm_data(dTdm[0]), .tdm_sync(dSync[0]), .busy(dBusy[0]),
    .slot(dSlot[0]), .underrun(dUnder[0]), .frame_count(dCount[0])
  );

  tdm_frame_scheduler #(
    .NUM_CH(NCH), .WORD_W(W), .FRAME_GAP(4), .IDLE_WORD(32'hDEADBEEF)
  ) u1 (
    .clock(clock), .reset(reset), .enable(enable), .ch_valid(ch_valid),
    .ch_data(ch_data), .ch_ready(dReady[1]), .clr_status(clr_status),
    .tdm_data(dTdm[1]), .tdm_sync(dSync[1]), .busy(dBusy[1]),
    .slot(dSlot[1]), .underrun(dUnder[1]), .frame_count(dCount[1])
  );

  function automatic int gapOf(input int i);
    return (i == 0) ? 0 : 4;
  endfunction

  function automatic logic [W-1:0] idleOf(input int i);
    return (i == 0) ? 32'h00000000 : 32'hDEADBEEF;
  endfunction

  function automatic int periodOf(input int i);
    return FB + gapOf(i);
  endfunction

  // Which slot (if any) the model says is being loaded this cycle.
  // mPos = -1 is the preparation cycle, 0..FB-1 the data bits, then the gap.
  function automatic void modelLoad(input int i, output bit act, output int s);
    act = 1'b0;
    s   = 0;
    if (mBusy[i]) begin
      if (mPos[i] < 0) begin
        act = 1'b1;
      end else if (mPos[i] < FB) begin
        if ((mPos[i] % W) == W - 1) begin
          if ((mPos[i] / W) < NCH - 1) begin
            act = 1'b1;
            s   = mPos[i] / W + 1;
          end else if (gapOf(i) == 0 && enable) begin
            act = 1'b1;
          end
        end
      end else if (mPos[i] == periodOf(i) - 1 && enable) begin
        act = 1'b1;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [NCH-1:0] valid,
                               input logic clr);
    @(negedge clock);
    #1;
    enable     = en;
    ch_valid   = valid;
    clr_status = clr;
  endtask

  task automatic waitSync(input int i, output bit found);
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clock);
      if (dSync[i]) found = 1'b1;
    end
    checkOutput($sformatf("dut%0d sync seen", i), 32'(found), 32'd1);
  endtask

  task automatic measurePeriod(input int i, output int p);
    bit found;
    p = -1;
    waitSync(i, found);
    if (found) begin
      found = 1'b0;
      for (int k = 1; k <= 400 && !found; k++) begin
        @(negedge clock);
        if (dSync[i]) begin
          found = 1'b1;
          p = k;
        end
      end
    end
  endtask

  task automatic captureFrame(input bit dropEnable, output logic [FB-1:0] bits);
    bit found;
    bits = '0;
    waitSync(0, found);
    if (found) begin
      for (int b = 0; b < FB; b++) begin
        if (b > 0) @(negedge clock);
        bits[FB-1-b] = dTdm[0];
        if (b == 0 && dropEnable) begin
          #1 enable = 1'b0;
        end
      end
    end
  endtask

  // Reference model: advance the position within the frame at every edge.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        mBusy[i]  <= 1'b0;
        mPos[i]   <= 0;
        mUnder[i] <= '0;
        mCount[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit           act;
        int           s;
        bit [NCH-1:0] setv;
        modelLoad(i, act, s);
        setv = '0;
        if (act) begin
          mWords[i][s] <= ch_valid[s] ? ch_data[s*W +: W] : idleOf(i);
          if (!ch_valid[s]) setv[s] = 1'b1;
        end
        mUnder[i] <= clr_status ? setv : (mUnder[i] | setv);
        if (mBusy[i] && mPos[i] == FB - 1) mCount[i] <= mCount[i] + 16'd1;
        if (!mBusy[i]) begin
          if (enable) begin
            mBusy[i] <= 1'b1;
            mPos[i]  <= -1;
          end
        end else if (mPos[i] == periodOf(i) - 1) begin
          if (enable) mPos[i] <= 0;
          else        mBusy[i] <= 1'b0;
        end else begin
          mPos[i] <= mPos[i] + 1;
        end
      end
    end
  end

  // Compare every output of both instances against the model each cycle.
  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      bit             act;
      int             s;
      logic           eTdm;
      logic           eSync;
      logic [2:0]     eSlot;
      logic [NCH-1:0] eReady;
      eTdm   = 1'b0;
      eSync  = 1'b0;
      eSlot  = '0;
      eReady = '0;
      if (mBusy[i] && mPos[i] >= 0 && mPos[i] < FB) begin
        eSlot = 3'(mPos[i] / W);
        eTdm  = mWords[i][mPos[i] / W][W - 1 - (mPos[i] % W)];
        eSync = (mPos[i] == 0);
      end
      modelLoad(i, act, s);
      if (act && ch_valid[s]) eReady[s] = 1'b1;
      checkOutput($sformatf("dut%0d tdm_data", i), 32'(dTdm[i]), 32'(eTdm));
      checkOutput($sformatf("dut%0d tdm_sync", i), 32'(dSync[i]), 32'(eSync));
      checkOutput($sformatf("dut%0d busy", i), 32'(dBusy[i]), 32'(mBusy[i]));
      checkOutput($sformatf("dut%0d slot", i), 32'(dSlot[i]), 32'(eSlot));
      checkOutput($sformatf("dut%0d ch_ready", i), 32'(dReady[i]), 32'(eReady));
      checkOutput($sformatf("dut%0d underrun", i), 32'(dUnder[i]), 32'(mUnder[i]));
      checkOutput($sformatf("dut%0d frame_count", i), 32'(dCount[i]), 32'(mCount[i]));
    end
  end

  // Event counters used by the directed scenarios on the gap-free instance.
  always @(negedge clock) begin
    if (dSync[0]) syncCnt++;
    for (int s = 0; s < NCH; s++) begin
      if (dReady[0][s]) readyCnt[s]++;
    end
  end

  // Directed scenarios followed by a randomized soak.
  initial begin
    logic [FB-1:0] bits;
    logic [W-1:0]  wordsRef [NCH];
    bit            found;
    int            p;
    int            k;
    logic [15:0]   c0;

    for (int s = 0; s < NCH; s++) begin
      wordsRef[s] = 32'h555555F1 + 32'(s);
      readyCnt[s] = 0;
    end

    repeat (3) @(negedge clock);
    checkOutput("reset busy", 32'(dBusy[0]), 32'd0);
    checkOutput("reset frame_count", 32'(dCount[0]), 32'd0);
    #1 reset = 1'b1;

    // Single frame, every source valid.
    ch_data = {wordsRef[4], wordsRef[3], wordsRef[2], wordsRef[1], wordsRef[0]};
    syncCnt = 0;
    applyStimulus(1'b1, 5'b11111, 1'b0);
    captureFrame(1'b1, bits);
    repeat (200) @(negedge clock);
    for (int s = 0; s < NCH; s++) begin
      checkOutput($sformatf("t1 slot%0d bits", s), bits[FB-1-32*s -: 32], wordsRef[s]);
      checkOutput($sformatf("t1 ready count ch%0d", s), 32'(readyCnt[s]), 32'd1);
    end
    checkOutput("t1 sync count", 32'(syncCnt), 32'd1);
    checkOutput("t1 frame_count", 32'(dCount[0]), 32'd1);
    checkOutput("t1 underrun", 32'(dUnder[0]), 32'd0);

    // Single frame with source 2 starved.
    for (int s = 0; s < NCH; s++) readyCnt[s] = 0;
    applyStimulus(1'b1, 5'b11011, 1'b0);
    captureFrame(1'b1, bits);
    repeat (200) @(negedge clock);
    checkOutput("t2 slot2 bits", bits[95:64], 32'h00000000);
    checkOutput("t2 slot3 bits", bits[63:32], wordsRef[3]);
    checkOutput("t2 underrun", 32'(dUnder[0]), 32'h04);
    checkOutput("t2 gap underrun", 32'(dUnder[1]), 32'h04);
    checkOutput("t2 ready count ch2", 32'(readyCnt[2]), 32'd0);
    checkOutput("t2 ready count ch0", 32'(readyCnt[0]), 32'd1);
    checkOutput("t2 frame_count", 32'(dCount[0]), 32'd2);
    applyStimulus(1'b0, 5'b11111, 1'b1);
    applyStimulus(1'b0, 5'b11111, 1'b0);
    @(negedge clock);
    checkOutput("t2 underrun cleared", 32'(dUnder[0]), 32'd0);

    // Continuous frames: sync spacing and frame counting.
    applyStimulus(1'b1, 5'b11111, 1'b0);
    measurePeriod(0, p);
    checkOutput("t3 sync period nogap", 32'(p), 32'd160);
    measurePeriod(1, p);
    checkOutput("t4 sync period gap4", 32'(p), 32'd164);
    waitSync(0, found);
    c0 = dCount[0];
    repeat (3 * FB) @(negedge clock);
    checkOutput("t3 three frames counted", 32'(dCount[0]), 32'(c0 + 16'd3));

    // enable drops at bit 50: frame still completes, then silence.
    waitSync(0, found);
    repeat (50) @(negedge clock);
    #1 enable = 1'b0;
    k = 0;
    found = 1'b0;
    while (k < 400 && !found) begin
      @(negedge clock);
      k++;
      if (!dBusy[0]) found = 1'b1;
    end
    checkOutput("t5 cycles to idle", 32'(k), 32'd110);
    syncCnt = 0;
    repeat (300) @(negedge clock);
    checkOutput("t5 no further sync", 32'(syncCnt), 32'd0);

    // Reset at bit 70, then restart.
    applyStimulus(1'b1, 5'b11111, 1'b0);
    waitSync(0, found);
    repeat (70) @(negedge clock);
    #1 reset = 1'b0;
    #1;
    checkOutput("t6 busy in reset", 32'(dBusy[0]), 32'd0);
    checkOutput("t6 tdm_data in reset", 32'(dTdm[0]), 32'd0);
    checkOutput("t6 frame_count in reset", 32'(dCount[0]), 32'd0);
    checkOutput("t6 gap busy in reset", 32'(dBusy[1]), 32'd0);
    @(negedge clock);
    #1 reset = 1'b1;
    captureFrame(1'b1, bits);
    checkOutput("t6 slot0 after restart", bits[FB-1 -: 32], wordsRef[0]);
    repeat (200) @(negedge clock);
    checkOutput("t6 frame_count after restart", 32'(dCount[0]), 32'd1);

    // Randomized soak against the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clock);
      #1;
      enable     = ($urandom_range(0, 99) < 90);
      clr_status = ($urandom_range(0, 99) < 3);
      reset      = ($urandom_range(0, 999) < 3) ? 1'b0 : 1'b1;
      for (int s = 0; s < NCH; s++) begin
        ch_valid[s] = ($urandom_range(0, 99) < 85);
        ch_data[s*W +: W] = $urandom;
      end
    end
    @(negedge clock);
    #1 reset = 1'b1;
    enable = 1'b0;
    repeat (5) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
